com_rxs: RTL
============

COM_RXS -- requirements
Module: com_rxs

Interface
REQ-001 SHALL have parameter SOF, default 8'hD5, frame start byte.
REQ-002 SHALL have parameter TMO, default 8'd200, maximum idle cycles between bytes inside a frame.
REQ-003 SHALL have port clk, input, 1, single clock shared with com_rxf and com_rx.
REQ-004 SHALL have port rst, input, 1, reset, asynchronous, active-low.
REQ-005 SHALL have port fs, input, 1, start request; level held by the controller until fd is seen.
REQ-006 SHALL have port fd, output, 1, frame finished, good or bad.
REQ-007 SHALL have port din, input, 8, byte from com_rxf.
REQ-008 SHALL have port din_vld, input, 1, one-cycle strobe per new din byte.
REQ-009 SHALL have port btype, output, 4, bag type, bits [7:4] of the type byte.
REQ-010 SHALL have port didx, output, 4, device index, bits [3:0] of the type byte.
REQ-011 SHALL have port data_len, output, 12, payload length.
REQ-012 SHALL have port dout, output, 8, payload byte.
REQ-013 SHALL have port dout_vld, output, 1, payload byte strobe.
REQ-014 SHALL have port stat, output, 4, status: bit0 ok, bit1 csum_err, bit2 len_err, bit3 timeout.

Function
REQ-015 SHALL implement the states IDLE, HUNT, TYPE, LENH, LENL, DATA, CSUM, DONE.
REQ-016 SHALL move from IDLE to HUNT when fs=1.
REQ-017 SHALL remain in HUNT, discarding bytes, until din_vld with din==SOF, then go to TYPE.
REQ-018 SHALL, in TYPE on din_vld, latch btype and didx, load the checksum accumulator with din, and go to LENH when btype[3]=1; otherwise it goes to CSUM.
REQ-019 SHALL, in LENH on din_vld, set len_err and go to DONE if din[7:4]!=0; otherwise it latches data_len[11:8].
REQ-020 SHALL, in LENL on din_vld, latch data_len[7:0] and go to DATA, or to CSUM if the length is 0.
REQ-021 SHALL, in DATA, pass each din_vld byte to dout with dout_vld one cycle later (registered, 1-cycle latency).
REQ-022 SHALL, in DATA, count received bytes with a 12-bit counter and go to CSUM after byte data_len.
REQ-023 SHALL accumulate the checksum as the 8-bit wrap-around sum of the type, length and payload bytes.
REQ-024 SHALL, in CSUM on din_vld, set ok if din equals the accumulator and csum_err otherwise, then go to DONE.
REQ-025 SHALL run an idle counter in TYPE through CSUM that clears on every din_vld.
REQ-026 SHALL, when the idle counter reaches TMO, set timeout and go to DONE; HUNT has no timeout.
REQ-027 SHALL assert fd=1 in DONE and hold stat, btype, didx and data_len stable while there.
REQ-028 SHALL go from DONE to IDLE when fs=0.
REQ-029 SHALL clear stat on the IDLE to HUNT transition.
REQ-030 SHALL ignore din_vld in IDLE and DONE.
REQ-031 SHALL accept a SOF value arriving in TYPE, LENx or DATA as ordinary data, with no resync.
REQ-032 SHALL, when din_vld and the timeout occur in the same cycle, have the byte win and the idle counter clear.
REQ-033 SHALL abort to HUNT when fs drops before DONE; stat stays 0 and fd is not asserted.
REQ-034 SHALL keep stat one-hot in DONE.

Reset
REQ-035 SHALL, on rst=0, force state=IDLE and set fd, dout_vld, dout, btype, didx, data_len, stat, counters and accumulator to 0, effective immediately and including mid-frame.
REQ-036 SHALL, after reset release, ignore bytes until fs rises again.

Structure
REQ-037 SHALL use the shared package for the BAG_* 4-bit type constants, the state encoding and the stat bit positions, common to com_rx and typec_tx.
REQ-038 SHALL place the 12-bit byte counter and TMO idle counter inline with no sub-module, except optionally com_rxs_cnt, a generic loadable counter reused for both.

Verification
REQ-039 SHALL pass: fs=1; bytes D5,51,51 -> btype=5, didx=1, fd=1, stat=0001, no dout_vld.
REQ-040 SHALL pass: fs=1; bytes D5,D5,00,03,AA,BB,CC,(D5+00+03+AA+BB+CC)mod256 -> data_len=3, dout=AA,BB,CC each 1 cycle after its din_vld, stat=0001.
REQ-041 SHALL pass: the same frame with the checksum byte XOR 01 -> stat=0010, payload still output.
REQ-042 SHALL pass: bytes D5,80,10 -> stat=0100, fd=1, no further byte consumed.
REQ-043 SHALL pass: D5,20, then no din_vld for 200 cycles -> stat=1000 at cycle 200; din_vld on cycle 200 instead -> no timeout.
REQ-044 SHALL pass: rst=0 during DATA after 2 of 3 bytes -> all outputs 0 asynchronously, state IDLE; fs=1 then a new good frame -> stat=0001.

Source files
------------

// File: rtl/com_rxs_pkg.sv
// -----------------------------------------------------------------------------
// com_rxs_pkg
// Shared definitions for the receive path (com_rxs, com_rx, typec_tx):
//   - BAG_* 4-bit bag type codes carried in the high nibble of the type byte
//   - receive-side state encoding
//   - bit positions inside the 4-bit status word
//   - stat_code(): builds a one-hot status word from a bit position
// -----------------------------------------------------------------------------
package com_rxs_pkg;

    // Bag types. Bit 3 set means the bag carries a length field and a payload.
    localparam logic [3:0] BAG_ACK    = 4'h1;
    localparam logic [3:0] BAG_STATUS = 4'h2;
    localparam logic [3:0] BAG_EVENT  = 4'h5;
    localparam logic [3:0] BAG_CFG    = 4'h8;
    localparam logic [3:0] BAG_DATA   = 4'hD;
    localparam int         BAG_LONG_BIT = 3;

    // Status word bit positions.
    localparam int STAT_OK   = 0;
    localparam int STAT_CSUM = 1;
    localparam int STAT_LEN  = 2;
    localparam int STAT_TMO  = 3;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HUNT = 3'd1,
        ST_TYPE = 3'd2,
        ST_LENH = 3'd3,
        ST_LENL = 3'd4,
        ST_DATA = 3'd5,
        ST_CSUM = 3'd6,
        ST_DONE = 3'd7
    } rxs_state_t;

    function automatic logic [3:0] stat_code(input int bit_pos);
        return 4'b0001 << bit_pos;
    endfunction

endpackage

// File: rtl/com_rxs.sv
// -----------------------------------------------------------------------------
// com_rxs -- frame parser for the receive path.
// Waits for a start request, hunts for the SOF byte, then parses
//   type byte, [length high, length low, payload...], checksum byte
// and reports a one-hot status word while holding fd high until the
// controller drops fs.
//
// Ports
//   clk       clock shared with com_rxf / com_rx
//   rst       asynchronous reset, active low
//   fs        start request, held by the controller until fd is seen
//   fd        frame finished (good or bad)
//   din       byte from com_rxf
//   din_vld   one-cycle strobe per din byte
//   btype     bag type, type byte [7:4]
//   didx      device index, type byte [3:0]
//   data_len  payload length
//   dout      payload byte
//   dout_vld  payload byte strobe, one cycle after the matching din_vld
//   stat      bit0 ok, bit1 csum_err, bit2 len_err, bit3 timeout
// -----------------------------------------------------------------------------
module com_rxs
    import com_rxs_pkg::*;
#(
    parameter logic [7:0] SOF = 8'hD5,
    parameter logic [7:0] TMO = 8'd200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fs,
    output logic        fd,
    input  logic [7:0]  din,
    input  logic        din_vld,
    output logic [3:0]  btype,
    output logic [3:0]  didx,
    output logic [11:0] data_len,
    output logic [7:0]  dout,
    output logic        dout_vld,
    output logic [3:0]  stat
);

    rxs_state_t  state;
    rxs_state_t  state_nx;
    logic        armed;
    logic        active;
    logic        tmo_hit;
    logic [11:0] byte_cnt;
    logic [7:0]  idle_cnt;
    logic [7:0]  csum;

    assign active = (state == ST_TYPE) || (state == ST_LENH) || (state == ST_LENL) ||
                    (state == ST_DATA) || (state == ST_CSUM);

    // A byte arriving on the last idle cycle wins over the timeout.
    assign tmo_hit = active && !din_vld && (idle_cnt == TMO - 8'd1);

    assign fd = (state == ST_DONE);

    // After reset a start request only counts once fs has been seen low,
    // so a request held across reset does not restart the parser.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            armed <= 1'b0;
        end else begin
            state <= state_nx;
            if (!fs)
                armed <= 1'b1;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (fs && armed) state_nx = ST_HUNT;
            // Controller withdrew the request while hunting: nothing to report.
            ST_HUNT: begin
                if (!fs)
                    state_nx = ST_IDLE;
                else if (din_vld && din == SOF)
                    state_nx = ST_TYPE;
            end
            ST_DONE: if (!fs) state_nx = ST_IDLE;
            default: begin
                if (!fs)
                    state_nx = ST_HUNT;
                else if (tmo_hit)
                    state_nx = ST_DONE;
                else if (din_vld) begin
                    case (state)
                        ST_TYPE: state_nx = din[4 + BAG_LONG_BIT] ? ST_LENH : ST_CSUM;
                        ST_LENH: state_nx = (din[7:4] != 4'd0) ? ST_DONE : ST_LENL;
                        ST_LENL: state_nx = ({data_len[11:8], din} == 12'd0) ? ST_CSUM : ST_DATA;
                        ST_DATA: if (byte_cnt + 12'd1 == data_len) state_nx = ST_CSUM;
                        ST_CSUM: state_nx = ST_DONE;
                        default: state_nx = state;
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            btype    <= '0;
            didx     <= '0;
            data_len <= '0;
            dout     <= '0;
            dout_vld <= 1'b0;
            stat     <= '0;
            byte_cnt <= '0;
            idle_cnt <= '0;
            csum     <= '0;
        end else begin
            dout_vld <= 1'b0;

            if (state == ST_IDLE && state_nx == ST_HUNT)
                stat <= '0;

            if (!active || din_vld)
                idle_cnt <= '0;
            else
                idle_cnt <= idle_cnt + 8'd1;

            if (active && fs) begin
                if (tmo_hit) begin
                    stat <= stat_code(STAT_TMO);
                end else if (din_vld) begin
                    case (state)
                        ST_TYPE: begin
                            btype    <= din[7:4];
                            didx     <= din[3:0];
                            data_len <= '0;
                            csum     <= din;
                        end
                        ST_LENH: begin
                            if (din[7:4] != 4'd0) begin
                                stat <= stat_code(STAT_LEN);
                            end else begin
                                data_len[11:8] <= din[3:0];
                                csum           <= csum + din;
                            end
                        end
                        ST_LENL: begin
                            data_len[7:0] <= din;
                            csum          <= csum + din;
                            byte_cnt      <= '0;
                        end
                        ST_DATA: begin
                            dout     <= din;
                            dout_vld <= 1'b1;
                            csum     <= csum + din;
                            byte_cnt <= byte_cnt + 12'd1;
                        end
                        ST_CSUM: begin
                            stat <= (din == csum) ? stat_code(STAT_OK) : stat_code(STAT_CSUM);
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule
